// File: rtl/front_panel_loader_pkg.sv
// Shared types and constants for the front-panel loader.
//   state_t  : loader FSM states (IDLE, WRITE, INC)
//   KEY_*    : index of each push button inside key_n / press vectors
package front_panel_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    INC   = 2'd2
  } state_t;

  localparam int NUM_KEYS = 3;
  localparam int KEY_ADDR = 0;
  localparam int KEY_DATA = 1;
  localparam int KEY_RUN  = 2;

endpackage

// File: rtl/front_panel_loader_if.sv
// Direct memory write port between the loader and LC-3 memory.
//   mem_we   : write request, held until mem_ack
//   mem_addr : write address / current load pointer
//   mem_data : write data, stable while mem_we is high
//   mem_ack  : memory accepted the current write
// master = loader side, slave = memory side.
interface front_panel_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ack;

  modport master (output mem_we, output mem_addr, output mem_data, input mem_ack);
  modport slave  (input mem_we, input mem_addr, input mem_data, output mem_ack);
endinterface

// File: rtl/front_panel_loader_key_debounce.sv
// One push-button conditioner: 2-flop synchronizer, stability counter and a
// one-cycle press pulse on an accepted 1->0 transition of the active-low key.
//   clk, reset : system clock, async active-high reset
//   key_n      : raw active-low button
//   press      : one-cycle pulse per accepted press (never on release)
module front_panel_loader_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1, sync2;
  logic          level;   // accepted (debounced) level, 1 = released
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      // Any return to the accepted level restarts the count, so bounce
      // shorter than the window never gets through.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= level & ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/front_panel_loader.sv
// Front-panel memory loader for the LC-3 FPGA build.
// Debounced KEY[0] latches SW as the load address, KEY[1] writes SW to memory
// at the load address (auto-increment after ack), KEY[2] toggles cpu_run.
// Loading only works while the CPU is halted.
//   clk, reset : system clock, async active-high reset
//   key_n      : raw active-low buttons [0]=addr [1]=data [2]=run/halt
//   sw         : raw switch word
//   bus        : memory write port (master side)
//   cpu_run    : 1 = LC-3 clock enabled
//   overrun    : sticky, a press was dropped (busy or lost priority)
module front_panel_loader
  import front_panel_loader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic [DATA_W-1:0]   sw,
  front_panel_loader_if.master bus,
  output logic                cpu_run,
  output logic                overrun
);

  logic [NUM_KEYS-1:0] press;
  logic [DATA_W-1:0]   sw_s1, sw_s2;
  state_t              state, state_nx;
  logic [ADDR_W-1:0]   addr, addr_nx;
  logic [DATA_W-1:0]   data, data_nx;
  logic                run_nx, ovr_nx;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    front_panel_loader_key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .key_n (key_n[k]),
      .press (press[k])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      data    <= '0;
      cpu_run <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nx;
      addr    <= addr_nx;
      data    <= data_nx;
      cpu_run <= run_nx;
      overrun <= ovr_nx;
    end
  end

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    data_nx  = data;
    run_nx   = cpu_run;
    ovr_nx   = overrun;
    case (state)
      IDLE: begin
        // Priority run > addr > data; losers of a tie are dropped.
        if (press[KEY_RUN]) begin
          run_nx = ~cpu_run;
          if (press[KEY_ADDR] | press[KEY_DATA]) ovr_nx = 1'b1;
        end else if (!cpu_run) begin
          if (press[KEY_ADDR]) begin
            addr_nx = ADDR_W'(sw_s2);
            if (press[KEY_DATA]) ovr_nx = 1'b1;
          end else if (press[KEY_DATA]) begin
            data_nx  = sw_s2;
            state_nx = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.mem_ack) state_nx = INC;
        if (|press)      ovr_nx   = 1'b1;
      end
      INC: begin
        addr_nx  = addr + ADDR_W'(1);
        state_nx = IDLE;
        if (|press) ovr_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request is a decode of the state flop: registered, and it drops the
  // moment reset forces the FSM back to IDLE.
  assign bus.mem_we   = (state == WRITE);
  assign bus.mem_addr = addr;
  assign bus.mem_data = data;

endmodule

// File: tb/tb_front_panel_loader.sv
module tb_front_panel_loader;
  localparam int DEB = 4;
  localparam int AW  = 16;
  localparam int DW  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    key_n;
  logic [DW-1:0] sw;
  logic          cpu_run, overrun;

  front_panel_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  front_panel_loader #(.DEBOUNCE_CYCLES(DEB), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .key_n   (key_n),
    .sw      (sw),
    .bus     (bus),
    .cpu_run (cpu_run),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] d;
    int          w;
  } wr_t;

  wr_t obs[$];
  wr_t expq[$];
  int  ack_dly  = 0;
  bit  ack_hold = 0;
  int  we_cyc   = 0;
  int  unstable = 0;
  logic [15:0] last_a, last_d;

  int n_chk = 0;
  int n_err = 0;

  // reference model state (transaction level)
  logic [15:0] m_addr;
  bit          m_run, m_ovr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // memory slave: ack after ack_dly extra cycles of mem_we, logs each write
  always @(negedge clk) begin
    if (reset) begin
      we_cyc = 0;
      bus.mem_ack = 1'b0;
    end else if (bus.mem_we) begin
      we_cyc++;
      if (we_cyc > 1 && (bus.mem_addr !== last_a || bus.mem_data !== last_d)) unstable++;
      last_a = bus.mem_addr;
      last_d = bus.mem_data;
      if (!ack_hold && we_cyc >= ack_dly + 1) begin
        bus.mem_ack = 1'b1;
        obs.push_back('{a: bus.mem_addr, d: bus.mem_data, w: we_cyc});
      end else begin
        bus.mem_ack = 1'b0;
      end
    end else begin
      we_cyc = 0;
      bus.mem_ack = 1'b0;
    end
  end

  task automatic press(input logic [2:0] m, input logic [15:0] v);
    @(negedge clk);
    sw    = v;
    key_n = ~m;
    repeat (DEB + 10) @(negedge clk);
    key_n = 3'b111;
    repeat (DEB + 10) @(negedge clk);
  endtask

  // what a press should do, from the front-panel rules
  task automatic m_press(input logic [2:0] m, input logic [15:0] v);
    if (m[2]) begin
      m_run = !m_run;
      if (m[1:0] != 2'b00) m_ovr = 1'b1;
    end else if (!m_run) begin
      if (m[0]) begin
        m_addr = v;
        if (m[1]) m_ovr = 1'b1;
      end else if (m[1]) begin
        expq.push_back('{a: m_addr, d: v, w: ack_dly + 1});
        m_addr = m_addr + 16'd1;
      end
    end
  endtask

  task automatic do_press(input logic [2:0] m, input logic [15:0] v);
    m_press(m, v);
    press(m, v);
  endtask

  task automatic compare_state(input string tag);
    int guard = 0;
    while (obs.size() < expq.size() && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_wrcnt"}, obs.size(), expq.size());
    while (obs.size() > 0 && expq.size() > 0) begin
      wr_t o, e;
      o = obs.pop_front();
      e = expq.pop_front();
      chk({tag, "_wr_addr"}, o.a, e.a);
      chk({tag, "_wr_data"}, o.d, e.d);
      chk({tag, "_we_width"}, o.w, e.w);
    end
    obs.delete();
    expq.delete();
    chk({tag, "_addr"}, bus.mem_addr, m_addr);
    chk({tag, "_run"}, cpu_run, m_run);
    chk({tag, "_ovr"}, overrun, m_ovr);
    chk({tag, "_we_idle"}, bus.mem_we, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_addr = 16'h0000;
    m_run  = 1'b0;
    m_ovr  = 1'b0;
    obs.delete();
    expq.delete();
  endtask

  initial begin
    int cnt;
    int guard;
    reset = 1'b1;
    key_n = 3'b111;
    sw    = '0;
    m_addr = 16'h0000;
    m_run  = 1'b0;
    m_ovr  = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_we",   bus.mem_we,   1'b0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_data", bus.mem_data, 16'h0000);
    chk("rst_run",  cpu_run,      1'b0);
    chk("rst_ovr",  overrun,      1'b0);
    reset = 1'b0;

    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.mem_we) cnt++;
    end
    chk("idle_we_cycles", cnt, 0);

    // load sequence, ack delay 3 -> 4-cycle request
    ack_dly = 3;
    do_press(3'b001, 16'h3000);
    do_press(3'b010, 16'h1021);
    do_press(3'b010, 16'h5260);
    compare_state("load");
    chk("load_ptr", bus.mem_addr, 16'h3002);

    // bounce: toggle every 2 cycles for 20 cycles, then hold low
    ack_dly = 1;
    m_press(3'b010, 16'h0BEE);
    @(negedge clk);
    sw = 16'h0BEE;
    for (int i = 0; i < 10; i++) begin
      key_n[1] = ~key_n[1];
      repeat (2) @(negedge clk);
    end
    key_n[1] = 1'b0;
    repeat (DEB + 10) @(negedge clk);
    key_n = 3'b111;
    repeat (DEB + 10) @(negedge clk);
    compare_state("bounce");

    // address wrap
    ack_dly = 0;
    do_press(3'b001, 16'hFFFF);
    do_press(3'b010, 16'hABCD);
    compare_state("wrap");
    chk("wrap_ptr", bus.mem_addr, 16'h0000);

    // randomized single presses
    for (int i = 0; i < 40; i++) begin
      int r;
      logic [2:0] m;
      r = $urandom_range(0, 9);
      m = (r < 4) ? 3'b001 : (r < 9) ? 3'b010 : 3'b100;
      ack_dly = $urandom_range(0, 5);
      do_press(m, 16'($urandom));
      compare_state("rnd");
    end

    // overrun and run lockout
    do_reset();
    ack_hold = 1'b1;
    press(3'b010, 16'h1111);
    chk("lock_we_held", bus.mem_we, 1'b1);
    press(3'b010, 16'h2222);
    chk("lock_ovr", overrun, 1'b1);
    chk("lock_data_frozen", bus.mem_data, 16'h1111);
    chk("lock_addr_frozen", bus.mem_addr, 16'h0000);
    ack_hold = 1'b0;
    repeat (5) @(negedge clk);
    chk("lock_nwr", obs.size(), 1);
    if (obs.size() > 0) begin
      chk("lock_wr_addr", obs[0].a, 16'h0000);
      chk("lock_wr_data", obs[0].d, 16'h1111);
    end
    obs.delete();
    m_addr = 16'h0001;
    m_ovr  = 1'b1;
    do_press(3'b100, 16'h0000);
    do_press(3'b001, 16'h1234);
    do_press(3'b010, 16'h5555);
    compare_state("lock");
    chk("lock_ptr", bus.mem_addr, 16'h0001);

    // simultaneous presses
    do_reset();
    ack_dly = 0;
    do_press(3'b011, 16'h4567);
    compare_state("simul01");
    do_press(3'b101, 16'h9999);
    compare_state("simul02");
    do_press(3'b100, 16'h0000);
    compare_state("simul_halt");

    // reset while a write is in flight
    ack_hold = 1'b1;
    @(negedge clk);
    sw = 16'h7777;
    key_n[1] = 1'b0;
    guard = 0;
    while (!bus.mem_we && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("rmw_we_before", bus.mem_we, 1'b1);
    reset = 1'b1;
    #1;
    chk("rmw_we_async", bus.mem_we, 1'b0);
    chk("rmw_addr", bus.mem_addr, 16'h0000);
    @(negedge clk);
    key_n = 3'b111;
    reset = 1'b0;
    ack_hold = 1'b0;
    repeat (20) @(negedge clk);
    chk("rmw_no_write", obs.size(), 0);
    chk("rmw_we_after", bus.mem_we, 1'b0);

    chk("addr_data_stable", unstable, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
